// File: rtl/port_output_queues.sv
// port_output_queues: steers each input word into one of NUM_PORTS show-ahead FIFOs by in_ctl[7:0]
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_wr/in_ctl/in_data input word strobe, control word ([7:0] = egress port), data word
//   out_valid/out_ready per-port head valid / consumer ready
//   out_ctl/out_data    per-port head control/data, port p at [p*WIDTH +: WIDTH]
//   fifo_full           per-port count == depth
//   drop_pulse          high one cycle after a dropped word
//   drop_count          saturating drop counter, built only when QUEUE_DROP_STATS_EN is defined
module port_output_queues #(
   parameter int DATA_WIDTH      = 480,
   parameter int CTRL_WIDTH      = 32,
   parameter int NUM_PORTS       = 4,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_wr,
   input  logic [CTRL_WIDTH-1:0]            in_ctl,
   input  logic [DATA_WIDTH-1:0]            in_data,
   output logic [NUM_PORTS-1:0]             out_valid,
   input  logic [NUM_PORTS-1:0]             out_ready,
   output logic [NUM_PORTS*CTRL_WIDTH-1:0]  out_ctl,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
   output logic [NUM_PORTS-1:0]             fifo_full,
   output logic                             drop_pulse,
   output logic [15:0]                      drop_count
);
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
   logic [NUM_PORTS-1:0] push, pop;
   logic drop;
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic [DATA_WIDTH-1:0] mem_data [DEPTH];
      logic [CTRL_WIDTH-1:0] mem_ctl [DEPTH];
      logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
      logic [FIFO_DEPTH_LOG2:0] count;
      logic sel;
      assign sel = in_wr && in_ctl[7:0] == 8'(i);
      assign out_valid[i] = count != '0;
      assign fifo_full[i] = count == FULL;
      assign pop[i] = out_valid[i] & out_ready[i];
      // a full FIFO still accepts a word when its head leaves in the same cycle
      assign push[i] = sel && (!fifo_full[i] || pop[i]);
      assign out_ctl[i*CTRL_WIDTH +: CTRL_WIDTH] = mem_ctl[rd_ptr];
      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_data[rd_ptr];
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[i]) wr_ptr <= wr_ptr + 1'b1;
            if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
            count <= (push[i] && !pop[i]) ? count + 1'b1 : (pop[i] && !push[i]) ? count - 1'b1 : count;
         end
      end
      always_ff @(posedge clk) begin
         if (push[i]) begin
            mem_ctl[wr_ptr]  <= in_ctl;
            mem_data[wr_ptr] <= in_data;
         end
      end
   end
   // covers both an out-of-range port index and a full FIFO without a same-cycle pop
   assign drop = in_wr && push == '0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_pulse <= 1'b0;
      else drop_pulse <= drop;
   end
`ifdef QUEUE_DROP_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_count <= '0;
      else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
   end
`else
   assign drop_count = '0;
`endif
endmodule

// File: tb/tb_port_output_queues.sv
// tb_port_output_queues: randomized and directed checks of port_output_queues against a queue-based model
module tb_port_output_queues;
   localparam int DW = 480, CW = 32, NP = 4;
   logic clk = 0, rst = 0, in_wr = 0;
   logic [CW-1:0] in_ctl = '0;
   logic [DW-1:0] in_data = '0;
   logic [NP-1:0] out_valid, out_ready = '0, fifo_full;
   logic [NP*CW-1:0] out_ctl;
   logic [NP*DW-1:0] out_data;
   logic drop_pulse;
   logic [15:0] drop_count;
   int vectors = 0, miscompares = 0;
   logic [DW-1:0] q_d [NP][$];
   logic [CW-1:0] q_c [NP][$];
   logic exp_pulse = 0;
   int exp_cnt = 0;

   port_output_queues dut (
      .clk(clk), .rst(rst), .in_wr(in_wr), .in_ctl(in_ctl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctl(out_ctl), .out_data(out_data),
      .fifo_full(fifo_full), .drop_pulse(drop_pulse), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r = '0;
      for (int k = 0; k < DW / 32; k++) r = {r[DW-33:0], 32'($urandom())};
      return r;
   endfunction

   function automatic int sat_cnt(input int c);
`ifdef QUEUE_DROP_STATS_EN
      return c > 65535 ? 65535 : c;
`else
      return 0;
`endif
   endfunction

   task automatic compare_all();
      for (int p = 0; p < NP; p++) begin
         check($sformatf("valid%0d", p), out_valid[p], q_d[p].size() != 0);
         check($sformatf("full%0d", p), fifo_full[p], q_d[p].size() == 4);
         if (q_d[p].size() != 0) begin
            check($sformatf("data%0d", p), out_data[p*DW +: DW], q_d[p][0]);
            check($sformatf("ctl%0d", p), out_ctl[p*CW +: CW], q_c[p][0]);
         end
      end
      check("drop_pulse", drop_pulse, exp_pulse);
      check("drop_count", drop_count, 16'(sat_cnt(exp_cnt)));
   endtask

   task automatic clear_model();
      for (int p = 0; p < NP; p++) begin
         q_d[p].delete();
         q_c[p].delete();
      end
      exp_pulse = 0;
      exp_cnt = 0;
   endtask

   // called at a falling edge: check outputs, apply inputs, advance model and DUT by one clock
   task automatic step(input logic wr, input logic [7:0] port, input logic [NP-1:0] rdy);
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic [NP-1:0] pops;
      logic dropped;
      compare_all();
      d = rnd_data();
      c = {24'($urandom()), port};
      in_wr = wr; in_ctl = c; in_data = d; out_ready = rdy;
      for (int p = 0; p < NP; p++) pops[p] = rdy[p] && q_d[p].size() != 0;
      dropped = wr && (port >= NP || (q_d[port[1:0]].size() == 4 && !pops[port[1:0]]));
      for (int p = 0; p < NP; p++) if (pops[p]) begin
         void'(q_d[p].pop_front());
         void'(q_c[p].pop_front());
      end
      if (wr && !dropped) begin
         q_d[port[1:0]].push_back(d);
         q_c[port[1:0]].push_back(c);
      end
      exp_pulse = dropped;
      if (dropped) exp_cnt++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1;
      for (int p = 0; p < NP; p++) step(1, 8'(p), 4'hF);
      repeat (2) step(0, 0, 4'hF);
      repeat (5) step(1, 2, 4'b1011);
      repeat (5) step(0, 0, 4'hF);
      repeat (4) step(1, 1, 4'b1101);
      step(1, 1, 4'hF);
      repeat (5) step(0, 0, 4'hF);
      step(1, 8'h07, 4'hF);
      step(0, 0, 4'hF);
      for (int n = 0; n < 2000; n++)
         step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 5)), 4'($urandom() & $urandom()));
      rst = 0;
      #1;
      clear_model();
      compare_all();
      @(negedge clk);
      compare_all();
      rst = 1;
      step(1, 0, 4'h0);
      step(0, 0, 4'h0);
      repeat (5) step(0, 0, 4'hF);
      in_wr = 1; in_ctl = 32'h7; out_ready = 4'hF;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      exp_cnt += 65540;
      exp_pulse = 1;
      step(0, 0, 4'hF);
      compare_all();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
